// File: rtl/if_id_fetch_queue.sv
// rtl/if_id_fetch_queue.sv - IF->ID decoupling FIFO with flush and first-word fall-through
module if_id_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enq_valid,
    input  logic [XLEN-1:0]              enq_pc,
    input  logic [XLEN-1:0]              enq_ir,
    input  logic                         enq_pred,
    output logic                         enq_ready,
    output logic                         deq_valid,
    output logic [XLEN-1:0]              deq_pc,
    output logic [XLEN-1:0]              deq_ir,
    output logic                         deq_pred,
    input  logic                         deq_ready,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
        logic            pred;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               enq_fire;
    logic               deq_fire;

    assign enq_ready = (count_q != CNT_W'(DEPTH));
    assign deq_valid = (count_q != '0) && !flush;
    assign enq_fire  = enq_valid && enq_ready && !flush;
    assign deq_fire  = deq_valid && deq_ready && !flush;
    assign count     = count_q;

    // Power-of-two depth lets the pointers wrap on their own; occupancy decides full/empty.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (enq_fire) wr_d = wr_q + PTR_W'(1);
            if (deq_fire) rd_d = rd_q + PTR_W'(1);
            count_d = count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) mem_q[wr_q] <= '{pc: enq_pc, ir: enq_ir, pred: enq_pred};
    end

    // ID must see a clean NOP bubble whenever nothing valid is at the head.
    always_comb begin
        head     = mem_q[rd_q];
        deq_pc   = '0;
        deq_ir   = '0;
        deq_pred = 1'b0;
        if (deq_valid) begin
            deq_pc   = head.pc;
            deq_ir   = head.ir;
            deq_pred = head.pred;
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!reset_n)
        count_q <= CNT_W'(DEPTH));
    a_no_enq_full: assert property (@(posedge clk) disable iff (!reset_n)
        !(enq_fire && count_q == CNT_W'(DEPTH)));
    a_no_deq_empty: assert property (@(posedge clk) disable iff (!reset_n)
        !(deq_fire && count_q == '0));
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// tb/tb_if_id_fetch_queue.sv - scoreboard bench for if_id_fetch_queue
module tb_if_id_fetch_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
        logic            pred;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enq_valid;
    logic [XLEN-1:0] enq_pc;
    logic [XLEN-1:0] enq_ir;
    logic            enq_pred;
    logic            enq_ready;
    logic            deq_valid;
    logic [XLEN-1:0] deq_pc;
    logic [XLEN-1:0] deq_ir;
    logic            deq_pred;
    logic            deq_ready;
    logic            flush;
    logic [2:0]      count;

    int   n_cmp = 0;
    int   n_err = 0;
    int   mc    = 0;
    exp_t sb[$];

    if_id_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enq_valid (enq_valid),
        .enq_pc    (enq_pc),
        .enq_ir    (enq_ir),
        .enq_pred  (enq_pred),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_pc    (deq_pc),
        .deq_ir    (deq_ir),
        .deq_pred  (deq_pred),
        .deq_ready (deq_ready),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: occupancy counter plus expected-entry queue, evaluated mid-cycle.
    always @(negedge clk) begin
        bit   exp_enq, exp_deq, exp_vld;
        exp_t e;
        if (!reset_n) begin
            mc = 0;
            sb.delete();
            check("rst_count", 64'(count), 64'd0);
            check("rst_deq_valid", 64'(deq_valid), 64'd0);
        end else begin
            exp_vld = (mc != 0) && !flush;
            exp_enq = enq_valid && (mc != DEPTH) && !flush;
            exp_deq = exp_vld && deq_ready;
            check("count", 64'(count), 64'(mc));
            check("enq_ready", 64'(enq_ready), 64'(mc != DEPTH));
            check("deq_valid", 64'(deq_valid), 64'(exp_vld));
            if (!exp_vld) begin
                check("bubble_ir", 64'(deq_ir), 64'd0);
                check("bubble_pred", 64'(deq_pred), 64'd0);
                check("bubble_pc", 64'(deq_pc), 64'd0);
            end
            if (exp_deq) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("deq_pc", 64'(deq_pc), 64'(e.pc));
                    check("deq_ir", 64'(deq_ir), 64'(e.ir));
                    check("deq_pred", 64'(deq_pred), 64'(e.pred));
                end
            end
            if (exp_enq) sb.push_back('{pc: enq_pc, ir: enq_ir, pred: enq_pred});
            if (flush) begin
                sb.delete();
                mc = 0;
            end else begin
                mc = mc + int'(exp_enq) - int'(exp_deq);
            end
        end
    end

    initial begin
        int  i;
        int  guard;
        bit  acc;
        reset_n   = 1'b0;
        enq_valid = 1'b0;
        enq_pc    = '0;
        enq_ir    = '0;
        enq_pred  = 1'b0;
        deq_ready = 1'b0;
        flush     = 1'b0;
        step();
        step();
        check("init_enq_ready", 64'(enq_ready), 64'd1);
        check("init_deq_ir", 64'(deq_ir), 64'd0);
        reset_n = 1'b1;
        step();

        // async reset mid-fill
        for (int k = 0; k < 3; k++) begin
            enq_valid = 1'b1;
            enq_pc    = 32'h40 + 32'(4 * k);
            enq_ir    = 32'h0000_0013 + 32'(k << 7);
            enq_pred  = k[0];
            step();
        end
        enq_valid = 1'b0;
        check("fill3_count", 64'(count), 64'd3);
        reset_n = 1'b0;
        #1;
        check("async_count", 64'(count), 64'd0);
        check("async_deq_valid", 64'(deq_valid), 64'd0);
        check("async_deq_ir", 64'(deq_ir), 64'd0);
        check("async_enq_ready", 64'(enq_ready), 64'd1);
        step();
        reset_n = 1'b1;
        step();

        // fill to full, then a rejected 5th enqueue
        for (int k = 0; k < 4; k++) begin
            enq_valid = 1'b1;
            enq_pc    = 32'h60 + 32'(4 * k);
            enq_ir    = 32'h1000_0093 + 32'(k << 12);
            enq_pred  = 1'b0;
            step();
        end
        check("full_count", 64'(count), 64'd4);
        check("full_enq_ready", 64'(enq_ready), 64'd0);
        enq_pc = 32'h70;
        enq_ir = 32'hDEAD_0013;
        step();
        check("fifth_count", 64'(count), 64'd4);
        check("full_head_pc", 64'(deq_pc), 64'h60);

        // full with simultaneous enq/deq: only the dequeue fires
        deq_ready = 1'b1;
        step();
        check("simul_count", 64'(count), 64'd3);
        check("simul_head_pc", 64'(deq_pc), 64'h64);
        enq_valid = 1'b0;
        repeat (4) step();
        deq_ready = 1'b0;
        check("drain_count", 64'(count), 64'd0);

        // streaming across pointer wrap with a toggling consumer
        i     = 0;
        guard = 0;
        while (i < 10 && guard < 100) begin
            enq_valid = 1'b1;
            enq_pc    = 32'h100 + 32'(4 * i);
            enq_ir    = 32'h0030_0113 ^ 32'(i << 20);
            enq_pred  = i[1];
            deq_ready = guard[0];
            acc       = (mc != DEPTH);
            step();
            if (acc) i++;
            guard++;
        end
        check("wrap_guard", 64'(guard < 100), 64'd1);
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        repeat (6) step();
        deq_ready = 1'b0;
        check("wrap_sb_empty", 64'(sb.size()), 64'd0);
        check("wrap_count", 64'(count), 64'd0);

        // flush discards entries and the concurrent enqueue
        for (int k = 0; k < 3; k++) begin
            enq_valid = 1'b1;
            enq_pc    = 32'h180 + 32'(4 * k);
            enq_ir    = 32'h0000_0073 + 32'(k);
            enq_pred  = 1'b1;
            step();
        end
        flush     = 1'b1;
        enq_pc    = 32'h200;
        deq_ready = 1'b1;
        #1;
        check("flush_deq_valid", 64'(deq_valid), 64'd0);
        check("flush_enq_ready", 64'(enq_ready), 64'd1);
        step();
        flush     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        check("post_flush_count", 64'(count), 64'd0);
        step();
        check("post_flush_deq_valid", 64'(deq_valid), 64'd0);

        // prediction bit pass-through
        enq_valid = 1'b1;
        enq_pc    = 32'h300;
        enq_ir    = 32'h00B5_0463;
        enq_pred  = 1'b1;
        #1;
        check("no_bypass", 64'(deq_valid), 64'd0);
        step();
        enq_valid = 1'b0;
        enq_pred  = 1'b0;
        check("pred_deq_ir", 64'(deq_ir), 64'h00B5_0463);
        check("pred_deq_pred", 64'(deq_pred), 64'd1);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        check("pred_empty", 64'(deq_pred), 64'd0);
        check("ir_empty", 64'(deq_ir), 64'd0);
        step();
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
